// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Load/store burst sequencer between the core datapath and data_ram.
// One burst request (op, base address, length) is taken in IDLE. The block
// then walks consecutive addresses one word per cycle.
//   - Loads return each word on rd_data with a one-cycle rd_valid strobe.
//   - Stores accept one word per cycle under a wr_valid/wr_ready handshake.
// The end of the burst is marked by a one-cycle done pulse.
//
// Ports
//   clk        single clock, all state on posedge
//   rst        synchronous, active-high reset
//   req        start request, sampled only in IDLE
//   op         0 = load, 1 = store (sampled with req)
//   base_addr  first word address (sampled with req)
//   len        word count (sampled with req); 0 completes with no access
//   wr_data    store word from core
//   wr_valid   wr_data valid
//   wr_ready   store word accepted when wr_valid & wr_ready
//   rd_data    registered load word, holds between strobes
//   rd_valid   one-cycle strobe per loaded word
//   busy       high in every state except IDLE
//   done       one-cycle pulse at burst end
//   mem_addr   data_ram address (always the current burst address)
//   mem_data   data_ram write data (passthrough of wr_data)
//   mem_we     data_ram write enable
//   mem_dout   data_ram read data (combinational read of mem_addr)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for req; burst parameters latched on req
// LOAD  | one word read per cycle, no stalls
// STORE | one word written per cycle when wr_valid, stalls otherwise
// DONE  | single-cycle completion pulse, then back to IDLE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_access_ctrl #(
    parameter int DWIDTH     = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  op,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DWIDTH-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DWIDTH-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0]     mem_data,
    output logic                  mem_we,
    input  logic [DWIDTH-1:0]     mem_dout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [LEN_WIDTH-1:0]  cnt_nxt;
    logic                  op_q;
    logic                  op_nxt;
    logic                  last_word;
    logic                  advance;

    // ------------------------------------------------------------------
    // Outputs decoded from state. wr_ready and mem_we are confined to
    // STORE so a stray wr_valid in any other state can never write RAM.
    // ------------------------------------------------------------------
    assign wr_ready  = (state == STORE);
    assign mem_we    = wr_ready & op_q & wr_valid;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_addr  = addr_q;
    assign mem_data  = wr_data;

    // cnt_q is a down-counter of words still to move; the word moved while
    // it reads 1 is the last one of the burst.
    assign last_word = (cnt_q == LEN_WIDTH'(1));

    // A word moves every LOAD cycle, and in STORE only on an accepted word.
    assign advance   = (state == LOAD) | mem_we;

    // ------------------------------------------------------------------
    // Next-state and burst-register logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        cnt_nxt   = cnt_q;
        op_nxt    = op_q;
        case (state)
            IDLE: begin
                if (req) begin
                    addr_nxt = base_addr;
                    cnt_nxt  = len;
                    op_nxt   = op;
                    if (len == '0) begin
                        state_nxt = DONE;
                    end else if (op) begin
                        state_nxt = STORE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD, STORE: begin
                if (advance) begin
                    // Address wraps modulo 2^ADDR_WIDTH by plain overflow.
                    addr_nxt = addr_q + ADDR_WIDTH'(1);
                    cnt_nxt  = cnt_q - LEN_WIDTH'(1);
                    if (last_word) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            cnt_q    <= cnt_nxt;
            op_q     <= op_nxt;
            // The strobe follows every LOAD edge by one cycle; rd_data is
            // left untouched otherwise so the last word stays visible.
            rd_valid <= (state == LOAD);
            if (state == LOAD) begin
                rd_data <= mem_dout;
            end
        end
    end

endmodule
